// File: rtl/anubis_sigma.sv
// anubis_sigma: Anubis key addition (a ^ k) as a registered 2-entry skid stage.
// Optional SIGMA_PARITY_EN adds per-byte even parity of out_data (out_parity).
module anubis_sigma #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SIGMA_PARITY_EN
  ,
  output logic [WIDTH/8-1:0] out_parity
`endif
);

  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             rdy;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] res;
  logic             push;
  logic             pop;
  logic             ld_main;
  logic             ld_skid;
  logic             from_skid;

  assign res       = in_data ^ in_key;
  assign push      = in_valid & rdy;
  assign pop       = (cnt != 2'd0) & out_ready;
  assign in_ready  = rdy;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = main_q;

  // occupancy and load control; main always holds the oldest entry
  always_comb begin
    cnt_nxt   = cnt;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    case (cnt)
      2'd0: begin
        if (push) begin
          ld_main = 1'b1;
          cnt_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          ld_main = 1'b1;
        end else if (push) begin
          ld_skid = 1'b1;
          cnt_nxt = 2'd2;
        end else if (pop) begin
          cnt_nxt = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          ld_main   = 1'b1;
          from_skid = 1'b1;
          if (push) ld_skid = 1'b1;
          else      cnt_nxt = 2'd1;
        end
      end
      default: cnt_nxt = 2'd0;
    endcase
  end

  // storage, count and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      rdy    <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      rdy <= (cnt_nxt != 2'd2);
      if (ld_main) main_q <= from_skid ? skid_q : res;
      if (ld_skid) skid_q <= res;
    end
  end

`ifdef SIGMA_PARITY_EN
  localparam int NB = WIDTH / 8;

  logic [NB-1:0] res_par;
  logic [NB-1:0] main_par;
  logic [NB-1:0] skid_par;

  // per-byte even parity of the incoming result
  always_comb begin
    res_par = '0;
    for (int j = 0; j < NB; j++) begin
      res_par[j] = ^res[8*j +: 8];
    end
  end

  // parity travels with its entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_par <= '0;
      skid_par <= '0;
    end else begin
      if (ld_main) main_par <= from_skid ? skid_par : res_par;
      if (ld_skid) skid_par <= res_par;
    end
  end

  assign out_parity = main_par;
`endif

endmodule

// File: tb/tb_anubis_sigma.sv
// tb_anubis_sigma: directed vector table plus handshake corner sequences.
// Parity checks are compiled in when SIGMA_PARITY_EN is defined.
module tb_anubis_sigma;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef SIGMA_PARITY_EN
  logic [W/8-1:0] out_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  anubis_sigma #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SIGMA_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] k;
    logic [W-1:0] e;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W/8-1:0] par(input logic [W-1:0] d);
    logic [W/8-1:0] p;
    for (int j = 0; j < W/8; j++) p[j] = ^d[8*j +: 8];
    return p;
  endfunction

  logic [W-1:0] sa[16];
  logic [W-1:0] sk[16];
  logic [W-1:0] r0, r1, r2;

  initial begin
    vecs[0] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF,
                128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF,
                128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000};
    vecs[1] = '{128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0,
                128'h0,
                128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0};
    vecs[2] = '{{16{8'hA5}}, {16{8'hA5}}, 128'h0};
    vecs[3] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                {128{1'b1}},
                128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF};
    vecs[4] = '{128'h0103_0000_0000_0000_0000_0000_0000_0000,
                128'h0,
                128'h0103_0000_0000_0000_0000_0000_0000_0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", W'(in_ready), W'(0));
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    chk("post_rst_out_valid", W'(out_valid), W'(0));

    // table: one vector at a time into an empty stage
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].a;
      in_key   = vecs[i].k;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].e);
`ifdef SIGMA_PARITY_EN
      chk($sformatf("vec%0d_par", i), W'(out_parity), W'(par(vecs[i].e)));
`endif
      step();
      chk($sformatf("vec%0d_drain", i), W'(out_valid), W'(0));
    end

`ifdef SIGMA_PARITY_EN
    in_valid = 1'b1;
    in_data  = vecs[4].a;
    in_key   = '0;
    step();
    in_valid = 1'b0;
    chk("par_hand", W'(out_parity), W'(16'h8000));
    step();
`endif

    // streaming: back-to-back with out_ready high
    for (int i = 0; i < 16; i++) begin
      sa[i] = {$urandom, $urandom, $urandom, $urandom};
      sk[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = sa[i];
      in_key   = sk[i];
      step();
      chk($sformatf("str%0d_data", i), out_data, sa[i] ^ sk[i]);
      chk($sformatf("str%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("str%0d_rdy", i), W'(in_ready), W'(1));
    end
    in_valid = 1'b0;
    step();
    chk("str_end_valid", W'(out_valid), W'(0));

    // backpressure: two accepted, third held
    r0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888 ^ 128'hF0;
    r1 = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0000 ^ 128'h0F;
    r2 = 128'h0 ^ 128'hCAFE;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    in_key    = 128'hF0;
    step();
    chk("bp1_rdy", W'(in_ready), W'(1));
    chk("bp1_data", out_data, r0);
    in_data = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0000;
    in_key  = 128'h0F;
    step();
    chk("bp2_rdy", W'(in_ready), W'(0));
    chk("bp2_data", out_data, r0);
    in_data = 128'h0;
    in_key  = 128'hCAFE;
    step();
    chk("bp3_rdy", W'(in_ready), W'(0));
    chk("bp3_data", out_data, r0);
    chk("bp3_valid", W'(out_valid), W'(1));
    step();
    chk("bp4_data", out_data, r0);
    out_ready = 1'b1;
    step();
    chk("bp_drain1", out_data, r1);
    chk("bp_drain1_rdy", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    chk("bp_drain2", out_data, r2);
    chk("bp_drain2_valid", W'(out_valid), W'(1));
    step();
    chk("bp_empty", W'(out_valid), W'(0));

    // reset with the stage full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'h55;
    in_key    = 128'h0;
    step();
    step();
    in_valid = 1'b0;
    chk("mrst_full", W'(in_ready), W'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", W'(out_valid), W'(0));
    chk("mrst_data", out_data, '0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mrst_rdy", W'(in_ready), W'(1));
    chk("mrst_valid2", W'(out_valid), W'(0));
    step();
    chk("mrst_nostale", W'(out_valid), W'(0));
    chk("mrst_data2", out_data, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anubis_sigma.md
Name: anubis_sigma

Overview:
- Anubis key-addition layer: sigma[k](a) = a XOR k, bitwise over the full state.
- Sits between round-function stages (gamma/theta/pi) and the round-key schedule output in the cipher datapath.
- Registered, streaming stage with a valid/ready handshake and a 2-entry skid buffer, so in_ready is a registered signal.

Parameters:
- WIDTH, 128, state/key width in bits; must be a multiple of 8 and at least 8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_key valid this cycle
- in_ready  output  1  stage can accept; registered
- in_data  input  WIDTH  cipher state a
- in_key  input  WIDTH  round key k
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  a XOR k, registered

Behaviour:
- Function: out_data[i] = in_data[i] ^ in_key[i] for every bit i.
  - Truth per bit: 0^0=0, 0^1=1, 1^0=1, 1^1=0.
  - No carries; no cross-bit interaction.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at a rising clk edge.
  - Output transfer occurs when out_valid && out_ready.
- XOR is computed at input acceptance; only the result is stored (WIDTH bits per entry).
- Storage: 2-entry FIFO (main register + skid register), occupancy count 0..2.
  - out_data always presents the oldest entry.
  - out_valid = (count != 0).
  - in_ready = (count < 2), driven from a register updated with count.
- Latency: an accepted input appears on out_data/out_valid the next cycle when empty. Throughput is 1 per cycle while out_ready stays high.
- Simultaneous accept and release:
  - count unchanged.
  - With count == 1: main register loads the new result.
  - With count == 2: skid moves to main, new result loads skid. Not reachable, since in_ready = 0 at count == 2.
- Full (count == 2):
  - in_ready = 0.
  - in_valid ignored.
  - Inputs must not be consumed.
- Empty (count == 0):
  - out_valid = 0.
  - out_ready ignored.
  - out_data holds the last value; not meaningful.
- Output stability: while out_valid && !out_ready, out_data and out_valid hold stable.
- Reset (asynchronous, active-high), applied at any time including mid-transfer:
  - count = 0, out_valid = 0, in_ready = 1 after deassertion (held at 0 while rst is high), out_data = 0.
  - All pending entries are discarded.
- No X propagation: storage registers reset to 0.

Optional Feature:
- Macro SIGMA_PARITY_EN.
- Defined:
  - Adds output port out_parity, WIDTH/8 bits.
  - Bit j = even parity (XOR-reduce) of out_data[8j+7:8j].
  - Stored alongside each entry with the same timing.
  - Resets to 0.
- Undefined: port absent; no parity logic.

Test Plan:
- Bit truth table: in_data=128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, in_key=128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF, out_ready=1 -> next cycle out_valid=1, out_data=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0000 (covers 0^0, 0^1, 1^0, 1^1).
- Identity/inverse: key=0 gives out_data=in_data. in_data=key=128'hA5A5…A5 gives out_data=0. Key=all-ones gives out_data=~in_data.
- Streaming: 16 back-to-back random vectors with out_ready=1 -> one result per cycle, in order, each equal to a^k, in_ready stays 1.
- Backpressure: out_ready=0 while sending 3 vectors.
  - After 2 accepts, in_ready=0.
  - Third vector is held, not lost.
  - out_data stable at the first result.
  - Raising out_ready drains all 3 in order.
- Reset mid-operation: assert rst with count=2 -> out_valid=0 immediately, out_data=0, in_ready=1 after release, no stale results emitted.
- With SIGMA_PARITY_EN: out_data=128'h01_03_00…00 -> out_parity[15]=1, out_parity[14]=0, others 0.
